// File: rtl/wb_prog_loader.sv
// wb_prog_loader: Wishbone classic responder that controls a small CPU.
// It holds the CPU control register, a 16 x 8-bit program store and the
// reset/step pulse generators. The CPU fetches program bytes combinationally
// through prog_addr_i/prog_data_o.
// Optional build macro: WB_PROG_READBACK_EN enables bus read-back of the
// program store. When it is undefined, program-store reads return zero.
module wb_prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [3:0]  prog_addr_i,
    output logic [7:0]  prog_data_o,
    input  logic [7:0]  cpu_out_i,
    input  logic [3:0]  cpu_pc_i,
    input  logic        cpu_halt_i,
    output logic        cpu_run_o,
    output logic        cpu_rst_o,
    output logic        cpu_step_o
);

    // Registered state
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        run_q, run_d;
    logic [2:0]  rst_cnt_q, rst_cnt_d;
    logic        step_q, step_d;
    logic [7:0]  prog_q [16];
    logic [7:0]  prog_d [16];

    // Bus decode
    logic        addr_hit;
    logic        req;
    logic [11:0] offset;
    logic [3:0]  prog_idx;
    logic        hit_ctrl;
    logic        hit_status;
    logic        hit_out;
    logic        hit_prog;
    logic        wr_en;
    logic [31:0] rd_data;

    // Bits that carry no meaning for this block
    logic        unused_bits;
    assign unused_bits = &{1'b0, wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:8]};

    assign addr_hit   = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign req        = wbs_cyc_i & wbs_stb_i & addr_hit & ~ack_q;
    assign offset     = wbs_adr_i[11:0];
    assign prog_idx   = wbs_adr_i[5:2];
    assign hit_ctrl   = (offset[11:2] == 10'h000);
    assign hit_status = (offset[11:2] == 10'h001);
    assign hit_out    = (offset[11:2] == 10'h002);
    assign hit_prog   = (offset[11:6] == 6'h04);
    assign wr_en      = req & wbs_we_i & wbs_sel_i[0];

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign cpu_run_o   = run_q;
    assign cpu_rst_o   = (rst_cnt_q != 3'd0);
    assign cpu_step_o  = step_q;
    assign prog_data_o = prog_q[prog_addr_i];

    // Read-data mux for the addressed register
    always_comb begin
        rd_data = '0;
        if (hit_ctrl) begin
            rd_data = {31'b0, run_q};
        end else if (hit_status) begin
            rd_data = {20'b0, cpu_pc_i, 5'b0, cpu_rst_o, cpu_halt_i, run_q};
        end else if (hit_out) begin
            rd_data = {24'b0, cpu_out_i};
        end else if (hit_prog) begin
`ifdef WB_PROG_READBACK_EN
            rd_data = {24'b0, prog_q[prog_idx]};
`else
            rd_data = '0;
`endif
        end
    end

    // Next-state logic: ack/data, control register, pulse generators, program store
    always_comb begin
        ack_d     = req;
        dat_d     = '0;
        run_d     = run_q;
        rst_cnt_d = (rst_cnt_q != 3'd0) ? rst_cnt_q - 3'd1 : rst_cnt_q;
        prog_d    = prog_q;

        if (req && !wbs_we_i) begin
            dat_d = rd_data;
        end

        if (wr_en && hit_ctrl) begin
            run_d = wbs_dat_i[0];
            if (wbs_dat_i[1]) begin
                rst_cnt_d = 3'd4;
            end
        end

        // Step fires next cycle only if the CPU reset is not active then,
        // which includes a reset requested by this same write.
        step_d = wr_en & hit_ctrl & wbs_dat_i[2] & ~wbs_dat_i[0] & (rst_cnt_d == 3'd0);

        if (wr_en && hit_prog && !run_q && !cpu_rst_o) begin
            prog_d[prog_idx] = wbs_dat_i[7:0];
        end
    end

    // State registers with synchronous reset; reset drops any in-flight request
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            run_q     <= 1'b0;
            rst_cnt_q <= '0;
            step_q    <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                prog_q[i] <= '0;
            end
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            run_q     <= run_d;
            rst_cnt_q <= rst_cnt_d;
            step_q    <= step_d;
            for (int unsigned i = 0; i < 16; i++) begin
                prog_q[i] <= prog_d[i];
            end
        end
    end

endmodule

// File: doc/wb_prog_loader.md
WB_PROG_LOADER -- requirements
Module: wb_prog_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, the Wishbone base address; the block decodes wbs_adr_i[31:12] == BASE_ADDR[31:12].
REQ-002 SHALL have these ports (name, direction, width, meaning):
- wb_clk_i, in, 1: single clock; all logic on its rising edge.
- wb_rst_i, in, 1: reset, synchronous, active-high.
- wbs_cyc_i, in, 1: bus cycle.
- wbs_stb_i, in, 1: strobe.
- wbs_we_i, in, 1: write enable.
- wbs_sel_i, in, 4: byte selects.
- wbs_adr_i, in, 32: byte address.
- wbs_dat_i, in, 32: write data.
- wbs_ack_o, out, 1: acknowledge.
- wbs_dat_o, out, 32: read data.
- prog_addr_i, in, 4: CPU fetch address.
- prog_data_o, out, 8: CPU fetch data.
- cpu_out_i, in, 8: CPU output port value.
- cpu_pc_i, in, 4: CPU program counter.
- cpu_halt_i, in, 1: CPU halted flag.
- cpu_run_o, out, 1: CPU run enable.
- cpu_rst_o, out, 1: CPU reset.
- cpu_step_o, out, 1: single-step pulse.

Function
REQ-003 SHALL be a Wishbone classic responder: a request is wbs_cyc_i & wbs_stb_i & address match & !wbs_ack_o.
REQ-004 SHALL assert wbs_ack_o exactly one cycle after the request is sampled, for one cycle only; back-to-back requests are therefore acked every second cycle.
REQ-005 SHALL never ack when the address does not match; the bus is left to other responders.
REQ-006 SHALL perform writes on the cycle the request is sampled, and only when wbs_sel_i[0]=1; wbs_sel_i[3:1] are ignored.
REQ-007 SHALL register wbs_dat_o together with wbs_ack_o; wbs_dat_o is 0 whenever wbs_ack_o=0.
REQ-008 Register map, by offset wbs_adr_i[11:0]:
- 0x000 CTRL (RW): bit0 run, bit1 rst_req, bit2 step.
- 0x004 STATUS (RO): bit0 cpu_run_o, bit1 cpu_halt_i, bit2 cpu_rst_o, bits[11:8] cpu_pc_i.
- 0x008 OUT (RO): bits[7:0] cpu_out_i.
- 0x100-0x13C PROG: 16 x 8-bit entries, index = wbs_adr_i[5:2].
- All other offsets: write ignored, read returns 0, acked normally.
REQ-009 CTRL.run SHALL drive cpu_run_o directly; CTRL reads return {29'b0, 1'b0, 1'b0, run}, so bits 1 and 2 always read back as 0.
REQ-010 A CTRL write with bit1=1 SHALL load a 3-bit counter with 4; cpu_rst_o=1 while the counter is nonzero, and the counter decrements each cycle.
- The pulse is therefore exactly 4 cycles, starting the cycle after the write.
- A new rst_req during the pulse reloads the counter to 4, extending the pulse.
REQ-011 A CTRL write with bit2=1 and written bit0=0 SHALL pulse cpu_step_o high for exactly one cycle, the cycle after the write.
- If the written bit0=1, step is ignored.
- If cpu_rst_o is active when the step would fire, the step is suppressed.
REQ-012 PROG writes SHALL be ignored (but acked) while cpu_run_o=1 or cpu_rst_o=1.
REQ-013 prog_data_o SHALL be a combinational read of PROG[prog_addr_i], independent of bus activity; a PROG write becomes visible on prog_data_o the cycle after the write.
REQ-014 If the bus does a CTRL write while a PROG write is in flight, no conflict is possible: only one request is accepted per ack.

Reset
REQ-015 On wb_rst_i=1 at a clock edge, the following SHALL be 0 on the next cycle: wbs_ack_o, wbs_dat_o, cpu_run_o, cpu_rst_o, cpu_step_o, the reset counter, CTRL, and all 16 PROG entries.
REQ-016 A request in flight when reset is asserted SHALL be dropped (no ack); the initiator retries.

Configuration
REQ-017 Macro WB_PROG_READBACK_EN controls PROG read-back.
- Defined: PROG reads return {24'b0, PROG[idx]}.
- Undefined: PROG reads return 0; writes and prog_data_o are unaffected.

Verification
REQ-018 The bench SHALL cover at least these scenarios:
- Write 0x00000A5 to BASE+0x104 with sel=0001 and run=0, then read it back -> ack 1 cycle after stb; readback 0x000000A5 with WB_PROG_READBACK_EN, 0x0 without; prog_addr_i=1 gives prog_data_o=0xA5.
- Write CTRL=0x2 -> cpu_rst_o high for exactly 4 cycles; STATUS bit2 reads 1 during the pulse; a second write at pulse cycle 2 extends the pulse to 6 cycles total.
- Write CTRL=0x4 with run=0 -> one-cycle cpu_step_o; write CTRL=0x5 -> no step, and cpu_run_o=1.
- With run=1, write 0x3C to BASE+0x108 -> write is acked, but the PROG[2] value is unchanged.
- Access at 0x3001_0000 -> no ack for 8 cycles; read BASE+0x200 -> ack with data 0; cpu_pc_i=9, cpu_halt_i=1 -> STATUS reads 0x00000902.
- Assert wb_rst_i in the cycle after a request is sampled -> no ack; all outputs are 0; PROG is cleared.
